// File: rtl/qdec.sv
// Quadrature decoder: synchronises A/B/Z, decodes Gray-code steps into a signed
// 32-bit position with preset, Z-index zeroing, direction, homing and error status.
module qdec #(
   parameter int SYNC_STAGES = 2   // legal 2..4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        a_i,
   input  logic        b_i,
   input  logic        z_i,
   input  logic [31:0] SETP,
   input  logic        SETP_WSTB,
   input  logic        RST_ON_Z,
   output logic [31:0] posn_o,
   output logic        dir_o,
   output logic        homed_o,
   output logic [1:0]  health_o
);

   localparam int FILL_W = $clog2(SYNC_STAGES + 1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [FILL_W-1:0]       fill_q, fill_d;
   logic [SYNC_STAGES-1:0]  a_sync_q, a_sync_d;
   logic [SYNC_STAGES-1:0]  b_sync_q, b_sync_d;
   logic [SYNC_STAGES-1:0]  z_sync_q, z_sync_d;
   logic [1:0]              prev_ab_q, prev_ab_d;
   logic                    z_prev_q, z_prev_d;
   logic [31:0]             posn_q, posn_d;
   logic                    dir_q, dir_d;
   logic                    homed_q, homed_d;
   logic [1:0]              health_q, health_d;

   logic [1:0] ab_s;
   logic       z_s;
   logic [1:0] delta;
   logic       run;
   logic       step_fwd;
   logic       step_rev;
   logic       quad_err;
   logic       z_rise;

   // Position of an AB pair along the forward cycle 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      logic [1:0] p;
      p = 2'd0;
      case (ab)
         2'b00:   p = 2'd0;
         2'b10:   p = 2'd1;
         2'b11:   p = 2'd2;
         2'b01:   p = 2'd3;
         default: p = 2'd0;
      endcase
      return p;
   endfunction

   assign ab_s     = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
   assign z_s      = z_sync_q[SYNC_STAGES-1];
   assign run      = (state_q == ST_RUN);
   assign delta    = gray_pos(ab_s) - gray_pos(prev_ab_q);
   assign step_fwd = run && (delta == 2'd1);
   assign step_rev = run && (delta == 2'd3);
   assign quad_err = run && (delta == 2'd2);
   assign z_rise   = run && z_s && !z_prev_q;

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      a_sync_d  = {a_sync_q[SYNC_STAGES-2:0], a_i};
      b_sync_d  = {b_sync_q[SYNC_STAGES-2:0], b_i};
      z_sync_d  = {z_sync_q[SYNC_STAGES-2:0], z_i};
      prev_ab_d = ab_s;
      z_prev_d  = z_s;
      posn_d    = posn_q;
      dir_d     = dir_q;
      homed_d   = homed_q;
      health_d  = health_q;

      // INIT waits until the synchroniser holds real pin samples, so the
      // reset value of the chain is never mistaken for a step or an error.
      case (state_q)
         ST_INIT: begin
            if (fill_q == FILL_W'(SYNC_STAGES)) begin
               state_d = ST_RUN;
            end else begin
               fill_d = fill_q + FILL_W'(1);
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      if (quad_err) begin
         health_d = 2'd1;
      end
      if (z_rise && enable_i) begin
         homed_d = 1'b1;
      end

      // Preset beats Z zeroing beats a step; losers are dropped.
      if (SETP_WSTB) begin
         posn_d   = SETP;
         health_d = 2'd0;
      end else if (z_rise && enable_i && RST_ON_Z) begin
         posn_d = 32'd0;
      end else if (enable_i && step_fwd) begin
         posn_d = posn_q + 32'd1;
         dir_d  = 1'b1;
      end else if (enable_i && step_rev) begin
         posn_d = posn_q - 32'd1;
         dir_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_INIT;
         fill_q    <= '0;
         a_sync_q  <= '0;
         b_sync_q  <= '0;
         z_sync_q  <= '0;
         prev_ab_q <= 2'b00;
         z_prev_q  <= 1'b0;
         posn_q    <= 32'd0;
         dir_q     <= 1'b0;
         homed_q   <= 1'b0;
         health_q  <= 2'd0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         a_sync_q  <= a_sync_d;
         b_sync_q  <= b_sync_d;
         z_sync_q  <= z_sync_d;
         prev_ab_q <= prev_ab_d;
         z_prev_q  <= z_prev_d;
         posn_q    <= posn_d;
         dir_q     <= dir_d;
         homed_q   <= homed_d;
         health_q  <= health_d;
      end
   end

   assign posn_o   = posn_q;
   assign dir_o    = dir_q;
   assign homed_o  = homed_q;
   assign health_o = health_q;

endmodule

// File: doc/qdec.md
QDEC -- requirements
Module: qdec

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops on each of a_i, b_i and z_i (legal 2..4).
REQ-002 SHALL have port clk_i  in  1  the single system clock; every flop uses its rising edge.
REQ-003 SHALL have port reset_i  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port enable_i  in  1  counting enable, synchronous to clk_i.
REQ-005 SHALL have port a_i  in  1  encoder channel A, asynchronous to clk_i.
REQ-006 SHALL have port b_i  in  1  encoder channel B, asynchronous to clk_i.
REQ-007 SHALL have port z_i  in  1  encoder index/Z, asynchronous to clk_i.
REQ-008 SHALL have port SETP  in  32  preset position value.
REQ-009 SHALL have port SETP_WSTB  in  1  one-cycle write strobe for SETP.
REQ-010 SHALL have port RST_ON_Z  in  1  when 1, a Z rising edge zeroes the position.
REQ-011 SHALL have port posn_o  out  32  signed position; this is the posn_i feed of the downstream pcomp block.
REQ-012 SHALL have port dir_o  out  1  direction of the last counted step: 1 = increment, 0 = decrement.
REQ-013 SHALL have port homed_o  out  1  a Z rising edge has been seen since reset.
REQ-014 SHALL have port health_o  out  2  0 = OK, 1 = quadrature error; codes 2 and 3 are never driven.

Function
REQ-015 SHALL pass a_i, b_i and z_i through SYNC_STAGES flops each; all decoding SHALL use only the synchronised values.
REQ-016 SHALL register the previous synchronised AB pair and compare it each cycle with the current pair.
REQ-017 SHALL count +1 on the forward transitions AB 00->10, 10->11, 11->01 and 01->00.
REQ-018 SHALL count -1 on the reverse transitions, i.e. the forward transitions reversed.
REQ-019 SHALL hold posn_o when AB is unchanged.
REQ-020 SHALL treat both A and B changing in one cycle as a quadrature error: no count, and health_o latched to 1.
REQ-021 SHALL keep health_o sticky at 1 until reset or SETP_WSTB.
REQ-022 SHALL update posn_o exactly SYNC_STAGES+1 clk_i cycles after an edge on a_i or b_i.
REQ-023 SHALL perform 32-bit two's-complement arithmetic with wrap: 0x7FFFFFFF+1 -> 0x80000000 and 0x00000000-1 -> 0xFFFFFFFF; no saturation, no flag.
REQ-024 SHALL, on SETP_WSTB=1, load posn_o with SETP on the next edge and clear health_o to 0, regardless of enable_i.
REQ-025 SHALL detect a Z rising edge as synchronised z going 0 -> 1; a level held high SHALL NOT re-trigger.
REQ-026 SHALL, on a Z rising edge with enable_i=1, set homed_o to 1; homed_o SHALL be cleared only by reset.
REQ-027 SHALL, on a Z rising edge with enable_i=1 and RST_ON_Z=1, load posn_o with 0.
REQ-028 SHALL resolve same-cycle events in the priority order SETP_WSTB > Z zeroing > quadrature step; lower-priority events are discarded, not deferred.
REQ-029 SHALL set dir_o on every counted step and hold it otherwise; a discarded step SHALL NOT change dir_o.
REQ-030 SHALL, while enable_i=0, still track the previous AB pair and still flag quadrature errors, but SHALL NOT count or act on Z.
REQ-031 SHALL NOT produce a spurious step when enable_i rises.
REQ-032 SHALL implement the first-sample state machine INIT -> RUN: in INIT the current AB is captured as the reference without counting or error, then the state moves to RUN.
REQ-033 SHALL return to INIT only on reset.

Reset
REQ-034 SHALL, on reset_i high, asynchronously clear posn_o=0, dir_o=0, homed_o=0, health_o=0, all synchroniser flops, the previous-AB register and the Z edge detector, and enter INIT.
REQ-035 SHALL, on reset release mid-rotation, not produce a count or error from the first sampled AB, per REQ-032.

Verification
REQ-036 SHALL verify forward rotation: enable=1, 8 forward AB steps spaced 4 cycles -> posn_o=8, dir_o=1, health_o=0, each step exactly SYNC_STAGES+1 cycles after its pin edge.
REQ-037 SHALL verify wrap: SETP=0x7FFFFFFF with strobe, then 1 forward step -> 0x80000000; SETP=0, then 1 reverse step -> 0xFFFFFFFF, dir_o=0.
REQ-038 SHALL verify the error path: AB 00->11 -> health_o=1 and posn_o unchanged; subsequent valid steps still count; SETP_WSTB -> health_o=0.
REQ-039 SHALL verify Z zeroing: RST_ON_Z=1, posn_o=100, Z pulse coincident with a forward step -> posn_o=0 and homed_o=1; Z held high 50 cycles -> no further zeroing.
REQ-040 SHALL verify priority: SETP_WSTB with SETP=500 in the same cycle as a Z edge and a step -> posn_o=500.
REQ-041 SHALL verify reset and enable: reset asserted mid-rotation with AB=11 -> all outputs 0; after release, first sample gives no step; with enable_i=0, 4 steps -> posn_o held; enable_i rising -> no step.
